// File: rtl/fastica_pkg.sv
// Shared constants, FSM encoding and result type for the FastICA back-projection engine.
package fastica_pkg;

    localparam int DW   = 26;
    localparam int FRAC = 16;
    localparam int N    = 4;
    localparam int PW   = 2 * DW;
    localparam int AW   = 2 * DW + 2;

    localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] SAT_MIN = -SAT_MAX - AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic                 ovf;
        logic signed [DW-1:0] val;
    } sat_t;

endpackage

// File: rtl/fastica_backproj_if.sv
// Matrix/sample/result bundle between a source driver and the back-projection engine.
interface fastica_backproj_if import fastica_pkg::*; ();

    logic signed [DW-1:0] w11, w12, w13, w14;
    logic signed [DW-1:0] w21, w22, w23, w24;
    logic signed [DW-1:0] w31, w32, w33, w34;
    logic signed [DW-1:0] w41, w42, w43, w44;
    logic signed [DW-1:0] y1, y2, y3, y4;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] z1, z2, z3, z4;
    logic                 out_valid;
    logic                 sat;

    modport master (
        output w11, w12, w13, w14, w21, w22, w23, w24,
               w31, w32, w33, w34, w41, w42, w43, w44,
               y1, y2, y3, y4, in_valid,
        input  in_ready, z1, z2, z3, z4, out_valid, sat
    );

    modport slave (
        input  w11, w12, w13, w14, w21, w22, w23, w24,
               w31, w32, w33, w34, w41, w42, w43, w44,
               y1, y2, y3, y4, in_valid,
        output in_ready, z1, z2, z3, z4, out_valid, sat
    );

endinterface

// File: rtl/fastica_mac.sv
// Shared signed multiply-accumulate with Q16 rescale and saturation of the running sum.
module fastica_mac import fastica_pkg::*; (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_clr,
    input  logic                 i_acc,
    input  logic signed [DW-1:0] i_a,
    input  logic signed [DW-1:0] i_b,
    output sat_t                 o_res
);

    // Floor rescale (arithmetic shift) then clamp to the DW-bit signed range.
    function automatic sat_t sat_shift(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] q;
        sat_t                 r;
        q     = acc >>> FRAC;
        r.ovf = 1'b0;
        r.val = q[DW-1:0];
        if (q > SAT_MAX) begin
            r.ovf = 1'b1;
            r.val = SAT_MAX[DW-1:0];
        end else if (q < SAT_MIN) begin
            r.ovf = 1'b1;
            r.val = SAT_MIN[DW-1:0];
        end
        return r;
    endfunction

    logic signed [PW-1:0] w_prod;
    logic signed [AW-1:0] w_sum;
    logic signed [AW-1:0] r_acc;

    assign w_prod = PW'(i_a) * PW'(i_b);
    assign w_sum  = r_acc + AW'(w_prod);
    assign o_res  = sat_shift(w_sum);

    // Clear wins over accumulate so the last term of a row restarts the next row at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_acc) begin
                r_acc <= w_sum;
            end
        end
    end

endmodule

// File: rtl/fastica_backproj.sv
// Back-projection z = W^T * y: FSM, index counter, operand muxes and result registers.
module fastica_backproj import fastica_pkg::*; (
    input  logic               clk_mul,
    input  logic               rst_mul,
    input  logic               en_mul,
    fastica_backproj_if.slave  bus
);

    state_t               r_state, w_next;
    logic [3:0]           r_idx;
    logic signed [DW-1:0] r_y [N];
    logic signed [DW-1:0] r_z [N];
    logic                 r_sat;
    logic                 r_out_valid;
    logic signed [DW-1:0] w_w [N][N];
    logic [1:0]           w_k, w_r;
    logic                 w_accept, w_clr, w_mac_en, w_in_ready;
    sat_t                 w_res;

    assign w_w[0][0] = bus.w11;  assign w_w[0][1] = bus.w12;
    assign w_w[0][2] = bus.w13;  assign w_w[0][3] = bus.w14;
    assign w_w[1][0] = bus.w21;  assign w_w[1][1] = bus.w22;
    assign w_w[1][2] = bus.w23;  assign w_w[1][3] = bus.w24;
    assign w_w[2][0] = bus.w31;  assign w_w[2][1] = bus.w32;
    assign w_w[2][2] = bus.w33;  assign w_w[2][3] = bus.w34;
    assign w_w[3][0] = bus.w41;  assign w_w[3][1] = bus.w42;
    assign w_w[3][2] = bus.w43;  assign w_w[3][3] = bus.w44;

    // idx[3:2] picks the output row, idx[1:0] the source; W is read transposed.
    assign w_k = r_idx[1:0];
    assign w_r = r_idx[3:2];

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_clr      = 1'b0;
        w_mac_en   = 1'b0;
        w_in_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    w_clr    = 1'b1;
                    w_next   = ST_MAC;
                end
            end
            ST_MAC: begin
                w_mac_en = 1'b1;
                w_clr    = (w_k == 2'd3);
                if (r_idx == 4'd15) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_mul) begin
        if (rst_mul) begin
            r_state <= ST_IDLE;
        end else if (en_mul) begin
            r_state <= w_next;
        end
    end

    fastica_mac u_mac (
        .clk   (clk_mul),
        .rst   (rst_mul),
        .i_en  (en_mul),
        .i_clr (w_clr),
        .i_acc (w_mac_en),
        .i_a   (w_w[w_k][w_r]),
        .i_b   (r_y[w_k]),
        .o_res (w_res)
    );

    always_ff @(posedge clk_mul) begin
        if (en_mul && w_accept) begin
            r_y[0] <= bus.y1;
            r_y[1] <= bus.y2;
            r_y[2] <= bus.y3;
            r_y[3] <= bus.y4;
        end
    end

    // out_valid is registered off DONE, so it rises on the edge that returns to IDLE.
    always_ff @(posedge clk_mul) begin
        if (rst_mul) begin
            r_idx       <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < N; i++) r_z[i] <= '0;
        end else if (en_mul) begin
            r_out_valid <= (r_state == ST_DONE);
            if (w_accept) begin
                r_idx <= '0;
                r_sat <= 1'b0;
            end
            if (w_mac_en) begin
                r_idx <= r_idx + 4'd1;
                if (w_k == 2'd3) begin
                    r_z[w_r] <= w_res.val;
                    r_sat    <= r_sat | w_res.ovf;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sat       = r_sat;
    assign bus.z1        = r_z[0];
    assign bus.z2        = r_z[1];
    assign bus.z3        = r_z[2];
    assign bus.z4        = r_z[3];

endmodule
